apb_write_sequencer: RTL
========================

// Module: apb_write_sequencer
// PURPOSE
//  APB master that programs the 3-register APB write slave (payload_0, payload_1, data_size).
//  Accepts one command (two payload bytes + 5-bit size) over a valid/ready handshake.
//  Issues three back-to-back APB write transfers, in order: addr 0, 1, 2.
//  Handles wait states, PSLVERR and a wait-state timeout; reports completion status.
// PARAMETERS
//  DATA_W    8   APB write-data width; payload width
//  ADDR_W    2   paddr width; drives the slave's write_select
//  MAX_WAIT  15  max consecutive pready=0 ACCESS cycles before abort; 0 = no timeout
// PORTS
//  pclk           in   1       APB clock; all logic on rising edge
//  preset         in   1       synchronous reset, active-high
//  cmd_valid      in   1       command available
//  cmd_ready      out  1       block can accept a command (high only in IDLE)
//  cmd_payload_0  in   DATA_W  value for register addr 0
//  cmd_payload_1  in   DATA_W  value for register addr 1
//  cmd_size       in   5       value for register addr 2 (zero-extended onto pwdata)
//  psel           out  1       APB select
//  penable        out  1       APB enable
//  pwrite         out  1       APB direction; 1 whenever psel=1
//  paddr          out  ADDR_W  APB address (0,1,2)
//  pwdata         out  DATA_W  APB write data
//  pready         in   1       slave ready; sampled only in ACCESS
//  pslverr        in   1       slave error; sampled with pready in ACCESS
//  done           out  1       1-cycle pulse: command finished (ok or aborted)
//  status         out  2       valid with done: 0 OK, 1 SLVERR, 2 TIMEOUT
//  err_idx        out  2       valid with done when status!=0: index of failing transfer
// BEHAVIOUR
//  - Reset (preset=1 at edge): state IDLE; psel, penable, pwrite, paddr, pwdata, done, status,
//    err_idx, transfer index and wait counter all 0. Commands ignored while preset=1.
//  - cmd_ready = (state==IDLE), combinational from state. Handshake = cmd_valid & cmd_ready.
//    Operands are captured into internal registers on handshake; inputs are don't-care afterwards.
//  - FSM IDLE -> SETUP -> ACCESS -> {SETUP | IDLE}. All APB outputs are registered.
//  - IDLE: on handshake -> SETUP, idx=0.
//  - SETUP (1 cycle): psel=1, penable=0, pwrite=1, paddr=idx, pwdata=operand[idx] -> ACCESS.
//  - ACCESS: psel=1, penable=1; paddr, pwdata held stable.
//      pready=0: stay, wait_cnt+1. If MAX_WAIT!=0 and wait_cnt==MAX_WAIT: abort TIMEOUT.
//      pready=1 & pslverr=1: abort SLVERR; remaining transfers are not issued.
//      pready=1 & pslverr=0 & idx<2: idx+1, wait_cnt=0 -> SETUP (psel stays 1, penable drops).
//      pready=1 & pslverr=0 & idx==2: finish OK.
//  - Finish/abort: next cycle psel=penable=0, state=IDLE, done=1, status/err_idx set;
//    cmd_ready is high in that same cycle, so a new command may be accepted. done lasts 1 cycle.
//  - Latency with zero wait states: handshake at cycle N -> done at N+7. Each wait state adds 1.
//  - Reset mid-transfer: bus returns to idle at the next edge. No done pulse; command is lost.
//  - cmd_size is placed on pwdata[4:0]; upper bits are 0. With DATA_W<5 the size is truncated.
// TESTING
//  1 reset; cmd {0xA5,0x3C,5'd17}, pready=1 -> paddr 0,1,2 / pwdata A5,3C,11, each SETUP+ACCESS;
//    done at handshake+7, status=0.
//  2 same cmd; slave holds pready=0 for 3 cycles on addr 1 -> ACCESS extended 3 cycles with
//    paddr/pwdata stable; done at handshake+10, status=0.
//  3 pslverr=1 with pready on addr 1 -> no addr 2 transfer; done, status=1, err_idx=1.
//  4 MAX_WAIT=4; pready stuck 0 on addr 0 -> abort after 4 wait cycles; psel=0 next;
//    status=2, err_idx=0.
//  5 cmd_valid held high continuously -> second command accepted in the done cycle;
//    its SETUP follows immediately. cmd_valid ignored while busy.
//  6 preset=1 during ACCESS of addr 1 -> psel=penable=0 next cycle, no done;
//    a new command after reset runs normally.

Source files
------------

// File: rtl/apb_write_sequencer.sv
// apb_write_sequencer: APB master writing payload_0, payload_1 and data_size (addr 0,1,2) per command
module apb_write_sequencer #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int MAX_WAIT = 15
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_payload_0,
  input  logic [DATA_W-1:0] cmd_payload_1,
  input  logic [4:0]        cmd_size,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              done,
  output logic [1:0]        status,
  output logic [1:0]        err_idx
);
  localparam int WAIT_W = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [1:0] ST_OK = 2'd0, ST_SLVERR = 2'd1, ST_TIMEOUT = 2'd2;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d, idx_n, status_q, status_d, err_q, err_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [DATA_W-1:0] op1_q, op1_d, pwdata_q, pwdata_d;
  logic [4:0] size_q, size_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic psel_q, psel_d, penable_q, penable_d, done_q, done_d, timeout;
  assign cmd_ready = state_q == IDLE;
  assign idx_n = idx_q + 2'd1;
  assign timeout = MAX_WAIT != 0 && wait_q == WAIT_W'(MAX_WAIT);
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wait_d    = wait_q;
    op1_d     = op1_q;
    size_d    = size_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    done_d    = 1'b0;
    status_d  = status_q;
    err_d     = err_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d  = SETUP;
        idx_d    = 2'd0;
        wait_d   = '0;
        op1_d    = cmd_payload_1;
        size_d   = cmd_size;
        psel_d   = 1'b1;
        paddr_d  = '0;
        pwdata_d = cmd_payload_0;
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      default: if (!pready && !timeout) begin
        wait_d = wait_q + 1'b1;
      end else if (pready && !pslverr && idx_q != 2'd2) begin
        state_d   = SETUP;
        idx_d     = idx_n;
        wait_d    = '0;
        penable_d = 1'b0;
        paddr_d   = ADDR_W'(idx_n);
        pwdata_d  = idx_n == 2'd1 ? op1_q : DATA_W'(size_q);
      end else begin
        // Finish or abort: bus goes idle and the outcome is reported for one cycle
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        paddr_d   = '0;
        pwdata_d  = '0;
        done_d    = 1'b1;
        status_d  = !pready ? ST_TIMEOUT : pslverr ? ST_SLVERR : ST_OK;
        err_d     = pready && !pslverr ? 2'd0 : idx_q;
      end
    endcase
  end
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      wait_q    <= '0;
      op1_q     <= '0;
      size_q    <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      done_q    <= 1'b0;
      status_q  <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wait_q    <= wait_d;
      op1_q     <= op1_d;
      size_q    <= size_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      done_q    <= done_d;
      status_q  <= status_d;
      err_q     <= err_d;
    end
  end
  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = psel_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign done    = done_q;
  assign status  = status_q;
  assign err_idx = err_q;
endmodule
